pnr_trig_sampler: RTL and testbench

- Front-end stage of the photon-number-resolving (PNR) path, clocked by ADC_CLK.
- Detects rising threshold crossings on the trigger ADC channel and enforces a clearance (dead-time) window between triggers.
- After a programmable delay, captures one sample of the PNR ADC channel and presents it as a single-cycle valid strobe plus data.
- The downstream photon-number classifier / GPIO encoder consumes this output.

---
 rtl/pnr_trig_sampler.sv | 111 +++++++++++
 tb/tb_pnr_trig_sampler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pnr_trig_sampler.sv
// rtl/pnr_trig_sampler.sv - PNR front end: trigger crossing detect, dead-time, delayed PNR capture.
// Optional macro PNR_MISSED_CNT_EN enables the missed-crossing counter.
module pnr_trig_sampler #(
  parameter int DW = 14,
  parameter int CW = 32
) (
  input  logic          ADC_CLK,
  input  logic          ADC_RST,
  input  logic [DW-1:0] trig_source_sig,
  input  logic [DW-1:0] pnr_source_sig,
  input  logic [DW-1:0] trig_threshold,
  input  logic [CW-1:0] trig_clearance,
  input  logic [CW-1:0] pnr_delay,
  output logic          trig_pulse,
  output logic          sample_valid,
  output logic [DW-1:0] sample_data,
  output logic          busy,
  output logic [CW-1:0] trig_count,
  output logic [CW-1:0] missed_count
);

  typedef enum logic [1:0] {ARMED, DELAY, HOLD} state_t;

  state_t              state, state_next;
  logic signed [DW-1:0] t0, t1;
  logic [DW-1:0]       p0;
  logic [CW-1:0]       d_lat, c_lat, cnt;
  logic [CW:0]         cnt_inc, c_ext;
  logic                x, accept, capture;

  assign x       = (t1 < $signed(trig_threshold)) && (t0 >= $signed(trig_threshold));
  assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  assign c_ext   = {1'b0, c_lat};

  // cnt holds the offset of the current cycle from the accepted event
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      ARMED: begin
        if (x) begin
          accept = 1'b1;
          if (pnr_delay == '0) begin
            capture    = 1'b1;
            state_next = (trig_clearance <= {{(CW-1){1'b0}}, 1'b1}) ? ARMED : HOLD;
          end else begin
            state_next = DELAY;
          end
        end
      end
      DELAY: begin
        if (cnt == d_lat) begin
          capture    = 1'b1;
          state_next = (cnt_inc >= c_ext) ? ARMED : HOLD;
        end
      end
      HOLD: begin
        if (cnt_inc >= c_ext) state_next = ARMED;
      end
      default: state_next = ARMED;
    endcase
  end

  always_ff @(posedge ADC_CLK) begin
    if (ADC_RST) begin
      state        <= ARMED;
      t0           <= '0;
      t1           <= '0;
      p0           <= '0;
      d_lat        <= '0;
      c_lat        <= '0;
      cnt          <= '0;
      trig_pulse   <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      busy         <= 1'b0;
      trig_count   <= '0;
    end else begin
      state        <= state_next;
      t0           <= $signed(trig_source_sig);
      t1           <= t0;
      p0           <= pnr_source_sig;
      trig_pulse   <= accept;
      sample_valid <= capture;
      busy         <= (state_next != ARMED);
      if (capture) sample_data <= p0;
      if (accept) begin
        d_lat      <= pnr_delay;
        c_lat      <= trig_clearance;
        cnt        <= {{(CW-1){1'b0}}, 1'b1};
        trig_count <= trig_count + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef PNR_MISSED_CNT_EN
  logic miss;
  assign miss = x && (state != ARMED);

  always_ff @(posedge ADC_CLK) begin
    if (ADC_RST)   missed_count <= '0;
    else if (miss) missed_count <= missed_count + 1'b1;
  end
`else
  assign missed_count = '0;
`endif

endmodule

// File: tb/tb_pnr_trig_sampler.sv
// tb/tb_pnr_trig_sampler.sv - directed self-checking bench for pnr_trig_sampler.
module tb_pnr_trig_sampler;
  localparam int DW = 14;
  localparam int CW = 32;

  logic          ADC_CLK = 1'b0;
  logic          ADC_RST = 1'b1;
  logic [DW-1:0] trig_source_sig = '0;
  logic [DW-1:0] pnr_source_sig = '0;
  logic [DW-1:0] trig_threshold = '0;
  logic [CW-1:0] trig_clearance = '0;
  logic [CW-1:0] pnr_delay = '0;
  logic          trig_pulse, sample_valid, busy;
  logic [DW-1:0] sample_data;
  logic [CW-1:0] trig_count, missed_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_missed = 0;
  int pulses, valids;

  pnr_trig_sampler #(.DW(DW), .CW(CW)) dut (
    .ADC_CLK(ADC_CLK), .ADC_RST(ADC_RST),
    .trig_source_sig(trig_source_sig), .pnr_source_sig(pnr_source_sig),
    .trig_threshold(trig_threshold), .trig_clearance(trig_clearance),
    .pnr_delay(pnr_delay), .trig_pulse(trig_pulse), .sample_valid(sample_valid),
    .sample_data(sample_data), .busy(busy), .trig_count(trig_count),
    .missed_count(missed_count)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int tr, input int pn);
    logic [31:0] tv, pv;
    tv = tr;
    pv = pn;
    @(negedge ADC_CLK);
    trig_source_sig = tv[DW-1:0];
    pnr_source_sig  = pv[DW-1:0];
    @(posedge ADC_CLK);
    #1;
  endtask

  task automatic idle(input int n, input int tr);
    for (int i = 0; i < n; i++) drive(tr, 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    ADC_RST = 1'b1;
    idle(2, 0);
    check("rst_pulse", {31'd0, trig_pulse}, 0);
    check("rst_valid", {31'd0, sample_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_data", {18'd0, sample_data}, 0);
    check("rst_tcnt", trig_count, 0);
    check("rst_mcnt", missed_count, 0);
    ADC_RST = 1'b0;

    // zero delay: capture in the event cycle
    trig_threshold = 14'd1000;
    pnr_delay      = 0;
    trig_clearance = 10;
    idle(3, 0);
    drive(2000, 1234);
    check("d0_pre_pulse", {31'd0, trig_pulse}, 0);
    drive(2000, 0);
    check("d0_pulse", {31'd0, trig_pulse}, 1);
    check("d0_valid", {31'd0, sample_valid}, 1);
    check("d0_data", {18'd0, sample_data}, 1234);
    check("d0_tcnt", trig_count, 1);
    check("d0_busy", {31'd0, busy}, 1);
    drive(2000, 0);
    check("d0_pulse_1cyc", {31'd0, trig_pulse}, 0);
    check("d0_valid_1cyc", {31'd0, sample_valid}, 0);
    check("d0_data_hold", {18'd0, sample_data}, 1234);
    idle(15, 0);
    check("d0_rearmed", {31'd0, busy}, 0);

    // delay 5, clearance 3, ramp, retrigger attempt at E+4
    pnr_delay      = 5;
    trig_clearance = 3;
    drive(2000, 100);
    drive(2000, 101);
    drive(2000, 102);
    drive(0, 103);
    drive(2000, 104);
    drive(2000, 105);
`ifdef PNR_MISSED_CNT_EN
    exp_missed = exp_missed + 1;
`endif
    check("d5_valid_early", {31'd0, sample_valid}, 0);
    check("d5_busy_e5", {31'd0, busy}, 1);
    check("d5_missed", missed_count, exp_missed);
    drive(2000, 106);
    check("d5_valid", {31'd0, sample_valid}, 1);
    check("d5_data", {18'd0, sample_data}, 105);
    check("d5_rearm_e6", {31'd0, busy}, 0);
    check("d5_tcnt", trig_count, 2);
    idle(5, 0);

    // clearance 20, delay 2, pulses every 8 cycles
    trig_clearance = 20;
    pnr_delay      = 2;
    pulses = 0;
    for (int k = 0; k < 33; k++) begin
      drive((k % 8 == 0) ? 2000 : 0, k);
      if (trig_pulse) pulses++;
    end
`ifdef PNR_MISSED_CNT_EN
    exp_missed = exp_missed + 2;
`endif
    check("win_pulses", pulses, 2);
    check("win_tcnt", trig_count, 4);
    check("win_missed", missed_count, exp_missed);
    idle(25, 0);

    // held level retriggers nothing
    trig_clearance = 5;
    pnr_delay      = 1;
    pulses = 0;
    for (int k = 0; k < 101; k++) begin
      drive(2000, 0);
      if (trig_pulse) pulses++;
    end
    check("hold_pulses", pulses, 1);
    check("hold_tcnt", trig_count, 5);
    idle(10, 0);

    // signed threshold
    trig_threshold = -14'sd100;
    pnr_delay      = 0;
    trig_clearance = 2;
    idle(3, -200);
    drive(-50, 0);
    drive(-50, 0);
    check("sgn_pulse", {31'd0, trig_pulse}, 1);
    check("sgn_tcnt", trig_count, 6);
    idle(5, -50);
    trig_threshold = 14'd200;
    pulses = 0;
    drive(-50, 0);
    drive(100, 0);
    drive(100, 0);
    if (trig_pulse) pulses++;
    drive(100, 0);
    if (trig_pulse) pulses++;
    check("sgn_no_pulse", pulses, 0);
    check("sgn_tcnt_same", trig_count, 6);
    idle(5, 0);

    // reset mid-delay aborts capture
    trig_threshold = 14'd1000;
    pnr_delay      = 10;
    trig_clearance = 3;
    drive(2000, 0);
    drive(2000, 0);
    drive(2000, 0);
    check("rm_busy_before", {31'd0, busy}, 1);
    ADC_RST = 1'b1;
    drive(2000, 0);
    ADC_RST = 1'b0;
    check("rm_busy", {31'd0, busy}, 0);
    check("rm_tcnt", trig_count, 0);
    valids = 0;
    for (int k = 0; k < 14; k++) begin
      drive(0, 0);
      if (sample_valid) valids++;
    end
    check("rm_no_valid", valids, 0);
    pnr_delay = 0;
    drive(2000, 77);
    drive(2000, 0);
    check("rm_fresh_pulse", {31'd0, trig_pulse}, 1);
    check("rm_fresh_data", {18'd0, sample_data}, 77);
    check("rm_fresh_tcnt", trig_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
